// File: rtl/full_adder.sv
// full_adder: WIDTH-bit adder with a combinational {carry, sum} path and a
// one-cycle registered copy (sum_q/carry_q) qualified by out_valid.
// Optional feature: define FULL_ADDER_OVF_EN to add ovf_q, a registered
// two's-complement overflow flag sharing the sum_q enable/reset rules.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q,
`ifdef FULL_ADDER_OVF_EN
    output logic             ovf_q,
`endif
    output logic             out_valid
);

    // The full result is one bit wider than the operands, so the carry out of
    // the MSB is kept and nothing wraps.
    logic [WIDTH:0] total;

    logic [WIDTH-1:0] sum_d;
    logic             carry_d;
    logic             out_valid_q;

`ifdef FULL_ADDER_OVF_EN
    logic ovf_d;
    logic ovf_now;
`endif

    // Combinational add: zero latency, independent of clk, rst and in_valid.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sum   = total[WIDTH-1:0];
        carry = total[WIDTH];
    end

`ifdef FULL_ADDER_OVF_EN
    // Signed overflow: operands agree in sign but the result sign differs.
    always_comb begin
        ovf_now = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end
`endif

    // Next-state for the registered result: capture on in_valid, else hold.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path leaves it unassigned and no latch is inferred.
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef FULL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (in_valid) begin
            sum_d   = sum;
            carry_d = carry;
`ifdef FULL_ADDER_OVF_EN
            ovf_d   = ovf_now;
`endif
        end
    end

    // Result and qualifier registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: reset is sampled on the clock edge only, so rst is an ordinary data input to these flops; it outranks in_valid.
        if (rst) begin
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so all flops update from pre-edge values.
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= in_valid;
`ifdef FULL_ADDER_OVF_EN
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: directed vectors on a WIDTH=1 and a WIDTH=8 instance.
// Registered results are checked through per-instance scoreboard queues.
// Combinational and hold/reset behaviour are checked directly.
module tb_full_adder;

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic [0:0] a1, b1, sum1, sum_q1;
    logic       cin1, v1, carry1, carry_q1, out_valid1;

    logic [7:0] a8, b8, sum8, sum_q8;
    logic       cin8, v8, carry8, carry_q8, out_valid8;
`ifdef FULL_ADDER_OVF_EN
    logic       ovf_q8;
`endif

    exp_t q1[$];
    exp_t q8[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1), .cin(cin1), .in_valid(v1),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
`ifdef FULL_ADDER_OVF_EN
        .ovf_q(),
`endif
        .out_valid(out_valid1)
    );

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8), .in_valid(v8),
        .sum(sum8), .carry(carry8), .sum_q(sum_q8), .carry_q(carry_q8),
`ifdef FULL_ADDER_OVF_EN
        .ovf_q(ovf_q8),
`endif
        .out_valid(out_valid8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic s, input logic c);
        exp_t e;
        e.s = {7'd0, s};
        e.c = c;
        e.o = 1'b0;
        q1.push_back(e);
    endtask

    task automatic push8(input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        e.s = s;
        e.c = c;
        e.o = o;
        q8.push_back(e);
    endtask

    // Monitor for the WIDTH=1 instance: pop and compare on every valid output.
    always @(negedge clk) begin
        if (out_valid1 === 1'b1) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut1 unexpected out_valid: got 1, expected 0");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 sum_q", 64'(sum_q1), 64'(e.s[0]));
                check("dut1 carry_q", 64'(carry_q1), 64'(e.c));
            end
        end
    end

    // Monitor for the WIDTH=8 instance.
    always @(negedge clk) begin
        if (out_valid8 === 1'b1) begin
            if (q8.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL dut8 unexpected out_valid: got 1, expected 0");
            end else begin
                exp_t e;
                e = q8.pop_front();
                check("dut8 sum_q", 64'(sum_q8), 64'(e.s));
                check("dut8 carry_q", 64'(carry_q8), 64'(e.c));
`ifdef FULL_ADDER_OVF_EN
                check("dut8 ovf_q", 64'(ovf_q8), 64'(e.o));
`endif
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    // Width-1 truth table {a,b,cin} -> {carry,sum}, in the walk order.
    logic [2:0] walk_in  [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    logic [1:0] walk_exp [8] = '{2'b00,  2'b01,  2'b01,  2'b10,  2'b01,  2'b10,  2'b10,  2'b11};

    // Width-8 stream vectors with hand-computed results.
    logic [7:0] s_a   [6] = '{8'hFF, 8'hFF, 8'h7F, 8'h80, 8'h12, 8'h80};
    logic [7:0] s_b   [6] = '{8'h01, 8'hFF, 8'h01, 8'h7F, 8'h34, 8'h80};
    logic       s_cin [6] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b1,  1'b0};
    logic [7:0] s_sum [6] = '{8'h00, 8'hFF, 8'h80, 8'hFF, 8'h47, 8'h00};
    logic       s_cy  [6] = '{1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1};
    logic       s_ovf [6] = '{1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b1};

    // Width-1 stream vectors {a,b,cin} -> {carry,sum}.
    logic [2:0] t_in  [4] = '{3'b111, 3'b100, 3'b011, 3'b000};
    logic [1:0] t_exp [4] = '{2'b11,  2'b01,  2'b10,  2'b00};

    initial begin
        // Reset held two cycles with valid, all-ones inputs.
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; v8 = 1'b1;
        step();
        step();
        check("rst dut1 sum_q", 64'(sum_q1), 64'd0);
        check("rst dut1 carry_q", 64'(carry_q1), 64'd0);
        check("rst dut1 out_valid", 64'(out_valid1), 64'd0);
        check("rst dut1 sum comb", 64'(sum1), 64'd1);
        check("rst dut1 carry comb", 64'(carry1), 64'd1);
        check("rst dut8 sum_q", 64'(sum_q8), 64'd0);
        check("rst dut8 out_valid", 64'(out_valid8), 64'd0);
        check("rst dut8 sum comb", 64'(sum8), 64'hFF);
        check("rst dut8 carry comb", 64'(carry8), 64'd1);
`ifdef FULL_ADDER_OVF_EN
        check("rst dut8 ovf_q", 64'(ovf_q8), 64'd0);
`endif

        rst = 1'b0;
        v1 = 1'b0;
        v8 = 1'b0;

        // Combinational walk of all eight width-1 input patterns.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] in;
            logic [1:0] ex;
            in = walk_in[i];
            ex = walk_exp[i];
            {a1, b1, cin1} = in;
            #1;
            check($sformatf("walk %03b sum", in), 64'(sum1), 64'(ex[0]));
            check($sformatf("walk %03b carry", in), 64'(carry1), 64'(ex[1]));
            #49;
        end
        step();
        check("idle dut1 out_valid", 64'(out_valid1), 64'd0);

        // Single valid capture of 1+1+1 followed by changed, invalid inputs.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        push1(1'b1, 1'b1);
        #1;
        check("pre-edge sum comb", 64'(sum1), 64'd1);
        check("pre-edge carry comb", 64'(carry1), 64'd1);
        check("pre-edge sum_q", 64'(sum_q1), 64'd0);
        check("pre-edge out_valid", 64'(out_valid1), 64'd0);
        step();
        check("post-edge out_valid", 64'(out_valid1), 64'd1);
        a1 = 1'b0; b1 = 1'b1; cin1 = 1'b0; v1 = 1'b0;
        step();
        check("drop out_valid", 64'(out_valid1), 64'd0);
        check("hold sum_q", 64'(sum_q1), 64'd1);
        check("hold carry_q", 64'(carry_q1), 64'd1);

        // Back-to-back valid stream on both instances.
        for (int i = 0; i < 6; i++) begin
            logic [2:0] in;
            logic [1:0] ex;
            in = t_in[i % 4];
            ex = t_exp[i % 4];
            {a1, b1, cin1} = in;
            v1 = 1'b1;
            push1(ex[0], ex[1]);
            a8 = s_a[i]; b8 = s_b[i]; cin8 = s_cin[i]; v8 = 1'b1;
            push8(s_sum[i], s_cy[i], s_ovf[i]);
            #1;
            check($sformatf("dut8 comb sum %0d", i), 64'(sum8), 64'(s_sum[i]));
            check($sformatf("dut8 comb carry %0d", i), 64'(carry8), 64'(s_cy[i]));
            step();
        end
        v1 = 1'b0;
        v8 = 1'b0;
        a8 = 8'h55; b8 = 8'h0A;
        step();
        step();
        check("stream end out_valid", 64'(out_valid8), 64'd0);
        check("stream hold sum_q", 64'(sum_q8), 64'h00);
        check("stream hold carry_q", 64'(carry_q8), 64'd1);

        // Reset and valid in the same cycle: the reset wins, nothing emerges.
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0; v1 = 1'b1;
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
        rst = 1'b1;
        step();
        check("rst-prio dut1 out_valid", 64'(out_valid1), 64'd0);
        check("rst-prio dut8 out_valid", 64'(out_valid8), 64'd0);
        check("rst-prio dut8 sum_q", 64'(sum_q8), 64'd0);
        check("rst-prio dut8 carry_q", 64'(carry_q8), 64'd0);
        rst = 1'b0;
        v1 = 1'b0;
        v8 = 1'b0;
        step();
        check("post-rst idle out_valid", 64'(out_valid8), 64'd0);

        // First valid after release appears one cycle later.
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; v1 = 1'b1;
        push1(1'b1, 1'b1);
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; v8 = 1'b1;
        push8(8'h00, 1'b1, 1'b0);
        step();
        check("release dut8 out_valid", 64'(out_valid8), 64'd1);
        v1 = 1'b0;
        v8 = 1'b0;
        step();
        step();

        check("dut1 queue drained", 64'(q1.size()), 64'd0);
        check("dut8 queue drained", 64'(q8.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
